// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, functs,
// ALU control codes, FSM states, datapath select codes and the DECODE
// dispatch function.
// Build option: CTRL_BNE_EN adds bne (opcode 000101) as a supported branch.
package mc_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_OR    = 6'b100101;

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_OR    = 4'b1000;
  localparam logic [3:0] ALU_LUI   = 4'b1001;
  localparam logic [3:0] ALU_PASSA = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b1011;

  localparam logic       SRCA_PC     = 1'b0;
  localparam logic       SRCA_REG    = 1'b1;
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_BOFF   = 2'b11;
  localparam logic [1:0] PCSRC_ALU   = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP  = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_RTYPE  = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  // Which kind of ALU operation the current state asks for.
  typedef enum logic [1:0] {
    CLS_ADD   = 2'd0,
    CLS_SUB   = 2'd1,
    CLS_RTYPE = 2'd2,
    CLS_IMM   = 2'd3
  } alu_cls_t;

  // Successor of DECODE; FETCH means the instruction is unsupported.
  function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn);
    state_t nxt;
    nxt = S_FETCH;
    case (op)
      OP_LW, OP_SW: nxt = S_MEMADR;
      OP_RTYPE:     nxt = (fn == FN_ADD || fn == FN_SUB || fn == FN_OR) ? S_RTYPE : S_FETCH;
      OP_BEQ:       nxt = S_BRANCH;
`ifdef CTRL_BNE_EN
      OP_BNE:       nxt = S_BRANCH;
`endif
      OP_ADDI, OP_ORI, OP_LUI: nxt = S_IEXEC;
      OP_J:         nxt = S_JUMP;
      default:      nxt = S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_ctrl_unit_if.sv
// Control bundle between the multi-cycle datapath (master) and the control
// unit (slave): instruction fields and ALU flag in, datapath controls out.
interface mc_ctrl_unit_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_zero;
  logic [3:0] alu_ct;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_op;
  logic [1:0] pc_src;
  logic       pc_write;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_write;
  logic       illegal;

  modport master (
    output opcode, funct, alu_zero,
    input  alu_ct, alu_src_a, alu_src_b, ext_op, pc_src, pc_write, iord,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal
  );

  modport slave (
    input  opcode, funct, alu_zero,
    output alu_ct, alu_src_a, alu_src_b, ext_op, pc_src, pc_write, iord,
           mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, illegal
  );
endinterface

// File: rtl/alu_ct_decode.sv
// Maps the state's ALU class plus opcode/funct onto the 4-bit ALU control code.
module alu_ct_decode
  import mc_ctrl_pkg::*;
(
  input  alu_cls_t   cls_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ct_o
);

  // Unknown funct/opcode falls back to add; DECODE never routes them here.
  always_comb begin
    alu_ct_o = ALU_ADD;
    case (cls_i)
      CLS_SUB: alu_ct_o = ALU_SUB;
      CLS_RTYPE: begin
        case (funct_i)
          FN_SUB:  alu_ct_o = ALU_SUB;
          FN_OR:   alu_ct_o = ALU_OR;
          default: alu_ct_o = ALU_ADD;
        endcase
      end
      CLS_IMM: begin
        case (opcode_i)
          OP_ORI:  alu_ct_o = ALU_OR;
          OP_LUI:  alu_ct_o = ALU_LUI;
          default: alu_ct_o = ALU_ADD;
        endcase
      end
      default: alu_ct_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mc_ctrl_unit.sv
// Main control FSM of the multi-cycle MIPS core (Moore; outputs decoded from
// the state register, branch PC enable also from alu_zero).
// Build option: CTRL_BNE_EN makes bne a branch with pc_write = ~alu_zero;
// without it bne is reported as illegal.
//
//  state  | meaning
//  FETCH  | read instruction, load IR, PC += 4
//  DECODE | compute branch target, dispatch on opcode/funct
//  MEMADR | base + offset address for lw/sw
//  MEMRD  | data memory read at ALUOut
//  MEMWB  | write MDR to rt
//  MEMWR  | data memory write at ALUOut
//  RTYPE  | register-register ALU op
//  ALUWB  | write ALUOut to rd
//  BRANCH | compare, conditional PC load from ALUOut
//  IEXEC  | register-immediate ALU op
//  IWB    | write ALUOut to rt
//  JUMP   | PC load from jump target
module mc_ctrl_unit
  import mc_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  mc_ctrl_unit_if.slave    ctl,
  output logic [3:0]       state_o
);

  state_t   state_q;
  alu_cls_t alu_cls;
  logic     br_take;

  // State register with synchronous reset and next-state dispatch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
    end else begin
      case (state_q)
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: state_q <= decode_next(ctl.opcode, ctl.funct);
        S_MEMADR: state_q <= (ctl.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
        S_MEMRD:  state_q <= S_MEMWB;
        S_RTYPE:  state_q <= S_ALUWB;
        S_IEXEC:  state_q <= S_IWB;
        default:  state_q <= S_FETCH;
      endcase
    end
  end

  // Branch condition; bne inverts the zero flag when supported.
  always_comb begin
`ifdef CTRL_BNE_EN
    br_take = (ctl.opcode == OP_BNE) ? ~ctl.alu_zero : ctl.alu_zero;
`else
    br_take = ctl.alu_zero;
`endif
  end

  alu_ct_decode u_alu_ct_decode (
    .cls_i    (alu_cls),
    .opcode_i (ctl.opcode),
    .funct_i  (ctl.funct),
    .alu_ct_o (ctl.alu_ct)
  );

  // Per-state datapath controls; reset masks every state-changing enable at once.
  always_comb begin
    alu_cls        = CLS_ADD;
    ctl.alu_src_a  = SRCA_PC;
    ctl.alu_src_b  = SRCB_REG;
    ctl.ext_op     = 1'b1;
    ctl.pc_src     = PCSRC_ALU;
    ctl.pc_write   = 1'b0;
    ctl.iord       = 1'b0;
    ctl.mem_read   = 1'b0;
    ctl.mem_write  = 1'b0;
    ctl.ir_write   = 1'b0;
    ctl.reg_dst    = 1'b0;
    ctl.mem_to_reg = 1'b0;
    ctl.reg_write  = 1'b0;
    ctl.illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.ir_write  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.pc_write  = 1'b1;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_BOFF;
        ctl.illegal   = (decode_next(ctl.opcode, ctl.funct) == S_FETCH);
      end
      S_MEMADR: begin
        ctl.alu_src_a = SRCA_REG;
        ctl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctl.iord     = 1'b1;
        ctl.mem_read = 1'b1;
      end
      S_MEMWB: begin
        ctl.mem_to_reg = 1'b1;
        ctl.reg_write  = 1'b1;
      end
      S_MEMWR: begin
        ctl.iord      = 1'b1;
        ctl.mem_write = 1'b1;
      end
      S_RTYPE: begin
        ctl.alu_src_a = SRCA_REG;
        alu_cls       = CLS_RTYPE;
      end
      S_ALUWB: begin
        ctl.reg_dst   = 1'b1;
        ctl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a = SRCA_REG;
        alu_cls       = CLS_SUB;
        ctl.pc_src    = PCSRC_ALUOUT;
        ctl.pc_write  = br_take;
      end
      S_IEXEC: begin
        ctl.alu_src_a = SRCA_REG;
        ctl.alu_src_b = SRCB_IMM;
        alu_cls       = CLS_IMM;
        ctl.ext_op    = (ctl.opcode != OP_ORI);
      end
      S_IWB: begin
        ctl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctl.pc_src   = PCSRC_JUMP;
        ctl.pc_write = 1'b1;
      end
      default: begin
      end
    endcase
    if (rst) begin
      ctl.pc_write  = 1'b0;
      ctl.ir_write  = 1'b0;
      ctl.mem_write = 1'b0;
      ctl.reg_write = 1'b0;
    end
  end

  assign state_o = state_q;

endmodule
